// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: sequences the UART receiver core's go/dr handshake and buffers
// bytes in a show-ahead FIFO. Define UART_RX_CTRL_OVERRUN_EN to build overrun detection.
module uart_rx_ctrl #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               uart_data,
   input  logic                     uart_dr,
   output logic                     uart_go,
   input  logic                     rx,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun,
   input  logic                     overrun_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StHold, StArmed, StRelease} state_e;

   state_e          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign uart_go = (state_q == StArmed);
   assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

   // ARMED is only entered while not full, so a push never meets a full FIFO.
   assign push = (state_q == StArmed) && uart_dr;
   assign pop  = rd_en && !empty;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHold:    if (!full) state_d = StArmed;
         StArmed:   if (uart_dr) state_d = StRelease;
         // Re-arm decision uses the post-update occupancy so a same-cycle pop counts.
         StRelease: if (!uart_dr) state_d = (count_d == CW'(DEPTH)) ? StHold : StArmed;
         default:   state_d = StHold;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StHold;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q] <= uart_data;
      end
   end

`ifdef UART_RX_CTRL_OVERRUN_EN
   logic rx_q, overrun_q;

   // A start-bit edge while parked in HOLD means the core dropped a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_q      <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         rx_q <= rx;
         if ((state_q == StHold) && rx_q && !rx) begin
            overrun_q <= 1'b1;
         end else if (overrun_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign overrun = overrun_q;
`else
   logic unused_ovr;
   assign unused_ovr = ^{rx, overrun_clr};
   assign overrun    = 1'b0;
`endif

endmodule
